// File: rtl/div_radix2_if.sv
// Request/response bundle between the EXE operand muxes, the radix-2 divider
// and the EXE result mux.
interface div_radix2_if #(
    parameter int XLEN = 64
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic            signed_i;
    logic            word_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            flush_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] quotient_o;
    logic [XLEN-1:0] remainder_o;

    modport master (
        output in_valid_i, signed_i, word_i, dividend_i, divisor_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, quotient_o, remainder_o
    );

    modport slave (
        input  in_valid_i, signed_i, word_i, dividend_i, divisor_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, quotient_o, remainder_o
    );
endinterface

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their *W forms.
// One quotient bit per CALC cycle on magnitudes; signs are reapplied on the way to DONE.
module div_radix2 #(
    parameter int XLEN = 64
) (
    input  logic        clk,
    input  logic        rst,
    div_radix2_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_X = CW'(XLEN - 1);
    localparam logic [CW-1:0] LAST_W = CW'(31);

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = v[31];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = 1'b0;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]      state_q,     state_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [XLEN:0]   racc_q,      racc_d;
    logic [XLEN-1:0] dsr_q,       dsr_d;
    logic [XLEN-1:0] dvs_q,       dvs_d;
    logic            word_q,      word_d;
    logic            neg_quo_q,   neg_quo_d;
    logic            neg_rem_q,   neg_rem_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] quo_q,       quo_d;
    logic [XLEN-1:0] rem_q,       rem_d;

    logic [XLEN-1:0] dd_op_s, dv_op_s, dd_abs_s, dv_abs_s;
    logic            dd_neg_s, dv_neg_s, div_zero_s, ovf_s;
    logic [XLEN-1:0] min_s;
    logic [XLEN:0]   r_shift_s, trial_s, r_next_s;
    logic            qbit_s;
    logic [XLEN-1:0] dsr_next_s, quo_raw_s, quo_neg_s, quo_fix_s;
    logic [XLEN-1:0] rem_raw_s, rem_neg_s, rem_fix_s;
    logic [CW-1:0]   last_s;

    // Condition the incoming operands: width/sign extension, magnitudes, special-case detection.
    always_comb begin
        dd_op_s = bus.dividend_i;
        dv_op_s = bus.divisor_i;
        if (bus.word_i) begin
            if (bus.signed_i) begin
                dd_op_s = sext32(bus.dividend_i);
                dv_op_s = sext32(bus.divisor_i);
            end else begin
                dd_op_s = zext32(bus.dividend_i);
                dv_op_s = zext32(bus.divisor_i);
            end
        end else begin
            dd_op_s = bus.dividend_i;
            dv_op_s = bus.divisor_i;
        end
        dd_neg_s   = bus.signed_i & dd_op_s[XLEN-1];
        dv_neg_s   = bus.signed_i & dv_op_s[XLEN-1];
        dd_abs_s   = dd_neg_s ? negate(dd_op_s) : dd_op_s;
        dv_abs_s   = dv_neg_s ? negate(dv_op_s) : dv_op_s;
        min_s      = bus.word_i ? ({XLEN{1'b1}} << 31) : ({XLEN{1'b1}} << (XLEN - 1));
        div_zero_s = (dv_op_s == {XLEN{1'b0}});
        ovf_s      = bus.signed_i & (dd_op_s == min_s) & (dv_op_s == {XLEN{1'b1}});
    end

    // One restoring step plus the sign/word fixup applied on the final step.
    always_comb begin
        r_shift_s  = {racc_q[XLEN-1:0], dsr_q[XLEN-1]};
        trial_s    = r_shift_s + ~{1'b0, dvs_q} + {{XLEN{1'b0}}, 1'b1};
        qbit_s     = ~trial_s[XLEN];
        r_next_s   = qbit_s ? trial_s : r_shift_s;
        dsr_next_s = {dsr_q[XLEN-2:0], qbit_s};
        quo_raw_s  = word_q ? zext32(dsr_next_s) : dsr_next_s;
        quo_neg_s  = neg_quo_q ? negate(quo_raw_s) : quo_raw_s;
        quo_fix_s  = word_q ? sext32(quo_neg_s) : quo_neg_s;
        rem_raw_s  = r_next_s[XLEN-1:0];
        rem_neg_s  = neg_rem_q ? negate(rem_raw_s) : rem_raw_s;
        rem_fix_s  = word_q ? sext32(rem_neg_s) : rem_neg_s;
        last_s     = word_q ? LAST_W : LAST_X;
    end

    // Next-state logic; flush wins over accept and over the result handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        racc_d      = racc_q;
        dsr_d       = dsr_q;
        dvs_d       = dvs_q;
        word_d      = word_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        out_valid_d = out_valid_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        if (bus.flush_i) begin
            state_d     = S_IDLE;
            cnt_d       = {CW{1'b0}};
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid_i) begin
                        word_d    = bus.word_i;
                        neg_quo_d = dd_neg_s ^ dv_neg_s;
                        neg_rem_d = dd_neg_s;
                        if (div_zero_s) begin
                            quo_d       = {XLEN{1'b1}};
                            rem_d       = bus.word_i ? sext32(bus.dividend_i) : bus.dividend_i;
                            out_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end else if (ovf_s) begin
                            quo_d       = dd_op_s;
                            rem_d       = {XLEN{1'b0}};
                            out_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            // Word ops park dividend bit 31 at the MSB so the walk starts there.
                            racc_d  = {(XLEN+1){1'b0}};
                            dsr_d   = bus.word_i ? (dd_abs_s << (XLEN - 32)) : dd_abs_s;
                            dvs_d   = dv_abs_s;
                            cnt_d   = {CW{1'b0}};
                            state_d = S_CALC;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    racc_d = r_next_s;
                    dsr_d  = dsr_next_s;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == last_s) begin
                        quo_d       = quo_fix_s;
                        rem_d       = rem_fix_s;
                        out_valid_d = 1'b1;
                        cnt_d       = {CW{1'b0}};
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready_i) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                    cnt_d       = {CW{1'b0}};
                    state_d     = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CW{1'b0}};
            racc_q      <= {(XLEN+1){1'b0}};
            dsr_q       <= {XLEN{1'b0}};
            dvs_q       <= {XLEN{1'b0}};
            word_q      <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            out_valid_q <= 1'b0;
            quo_q       <= {XLEN{1'b0}};
            rem_q       <= {XLEN{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            racc_q      <= racc_d;
            dsr_q       <= dsr_d;
            dvs_q       <= dvs_d;
            word_q      <= word_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            out_valid_q <= out_valid_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
        end
    end

    assign bus.in_ready_o  = (state_q == S_IDLE);
    assign bus.out_valid_o = out_valid_q;
    assign bus.quotient_o  = quo_q;
    assign bus.remainder_o = rem_q;
endmodule
